// File: rtl/i2c_pkg.sv
// Shared types and framing constants for the I2C write master.
package i2c_pkg;

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, FIN} state_t;

  typedef logic [1:0] quarter_t;

  localparam int START_Q         = 2;
  localparam int BIT_Q           = 4;
  localparam int ACK_Q           = 4;
  localparam int STOP_Q          = 3;
  localparam int BYTES_PER_FRAME = 3;
  localparam int BITS_PER_BYTE   = 8;
  localparam int DIV_W           = 10;

  function automatic logic last_quarter(input quarter_t q, input int n_quarters);
    return q == quarter_t'(n_quarters - 1);
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period divider: ticks on the last enabled cycle of each quarter.
module i2c_quarter_tick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clear,
  output logic o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == DIV_W'(CLK_DIV - 1));
  assign o_tick = i_en & w_last;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_write_master.sv
// Single-frame I2C write engine: START, address+W, two data bytes, STOP.
// All pad and handshake outputs are registered from next-state logic.
module i2c_write_master
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         CLK_DIV  = 125
) (
  input  logic        clk_i2c,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        start_i,
  input  logic [15:0] data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        nack_o,
  output logic        scl_o,
  output logic        sda_oe_o,
  input  logic        sda_i
);

  state_t      r_state, w_state;
  quarter_t    r_q, w_q;
  logic [2:0]  r_bit, w_bit;
  logic [1:0]  r_byte, w_byte;
  logic [23:0] r_shift, w_shift;
  logic        r_nack_flag, w_nack_flag;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        r_nack, w_nack;
  logic        r_scl, w_scl;
  logic        r_sda_oe, w_sda_oe;
  logic        w_clear;
  logic        w_tick;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk   (clk_i2c),
    .i_rst   (rst_i),
    .i_en    (en_i),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk_i2c) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_q         <= '0;
      r_bit       <= '0;
      r_byte      <= '0;
      r_shift     <= '0;
      r_nack_flag <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_nack      <= 1'b0;
      r_scl       <= 1'b1;
      r_sda_oe    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_q         <= w_q;
      r_bit       <= w_bit;
      r_byte      <= w_byte;
      r_shift     <= w_shift;
      r_nack_flag <= w_nack_flag;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_nack      <= w_nack;
      r_scl       <= w_scl;
      r_sda_oe    <= w_sda_oe;
    end
  end

  // Pad levels are set on the edge that enters each quarter, so every
  // branch below programs the levels of the quarter being entered.
  always_comb begin
    w_state     = r_state;
    w_q         = r_q;
    w_bit       = r_bit;
    w_byte      = r_byte;
    w_shift     = r_shift;
    w_nack_flag = r_nack_flag;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_nack      = 1'b0;
    w_scl       = r_scl;
    w_sda_oe    = r_sda_oe;
    w_clear     = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (en_i && start_i) begin
          w_state     = START;
          w_q         = '0;
          w_bit       = '0;
          w_byte      = '0;
          w_shift     = {DEV_ADDR, 1'b0, data_i};
          w_nack_flag = 1'b0;
          w_busy      = 1'b1;
          w_scl       = 1'b1;
          w_sda_oe    = 1'b0;
          w_clear     = 1'b1;
        end
      end
      START: begin
        if (w_tick) begin
          if (last_quarter(r_q, START_Q)) begin
            w_state  = BIT;
            w_q      = '0;
            w_scl    = 1'b0;
            w_sda_oe = ~r_shift[23];
          end else begin
            w_q      = r_q + 1'b1;
            w_sda_oe = 1'b1;
          end
        end
      end
      BIT: begin
        if (w_tick) begin
          w_q = r_q + 1'b1;
          if (r_q == 2'd0) begin
            w_scl = 1'b1;
          end else if (r_q == 2'd2) begin
            w_scl = 1'b0;
          end else if (last_quarter(r_q, BIT_Q)) begin
            w_q     = '0;
            w_shift = {r_shift[22:0], 1'b0};
            if (r_bit == 3'(BITS_PER_BYTE - 1)) begin
              w_state  = ACK;
              w_bit    = '0;
              w_sda_oe = 1'b0;
            end else begin
              w_bit    = r_bit + 1'b1;
              w_sda_oe = ~r_shift[22];
            end
          end
        end
      end
      ACK: begin
        if (w_tick) begin
          w_q = r_q + 1'b1;
          if (r_q == 2'd0) begin
            w_scl = 1'b1;
          end else if (r_q == 2'd2) begin
            w_scl       = 1'b0;
            w_nack_flag = sda_i;
          end else if (last_quarter(r_q, ACK_Q)) begin
            w_q = '0;
            if (r_nack_flag || r_byte == 2'(BYTES_PER_FRAME - 1)) begin
              w_state  = STOP;
              w_scl    = 1'b0;
              w_sda_oe = 1'b1;
            end else begin
              w_state  = BIT;
              w_byte   = r_byte + 1'b1;
              w_sda_oe = ~r_shift[23];
            end
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          w_q = r_q + 1'b1;
          if (r_q == 2'd0) begin
            w_scl = 1'b1;
          end else if (r_q == 2'd1) begin
            w_sda_oe = 1'b0;
          end else if (last_quarter(r_q, STOP_Q)) begin
            w_state = FIN;
            w_q     = '0;
            if (r_nack_flag) begin
              w_busy = 1'b0;
              w_nack = 1'b1;
            end else begin
              w_done = 1'b1;
            end
          end
        end
      end
      FIN: begin
        if (en_i) begin
          w_state = IDLE;
          w_busy  = 1'b0;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign nack_o   = r_nack;
  assign scl_o    = r_scl;
  assign sda_oe_o = r_sda_oe;

endmodule

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
- Single-master I2C write engine that services the codec configuration sequencer.
- Accepts a one-cycle start pulse with a 16-bit register word.
- Emits one frame: START, device address + W, data[15:8], data[7:0], STOP. Checks ACK after every byte.
- Reports progress through busy/done/nack using the exact handshake the sequencer expects. Sits between the sequencer and the codec's SCL/SDA pins.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit codec slave address (write byte 8'h34).
- CLK_DIV, 125, clk_i2c cycles per quarter SCL period (50 MHz gives 100 kHz). Legal range 2..1023.

Ports:
- clk_i2c  in  1  single clock.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  clock enable. Low freezes all state, including the divider. start_i is ignored while low.
- start_i  in  1  one-cycle request to send data_i.
- data_i  in  16  register word; sampled only on the accept edge.
- busy_o  out  1  transaction in progress.
- done_o  out  1  one-cycle pulse on successful frame.
- nack_o  out  1  one-cycle pulse when the frame aborted on NACK.
- scl_o  out  1  SCL level driven to pad.
- sda_oe_o  out  1  1 = pull SDA low; 0 = release (open drain).
- sda_i  in  1  SDA pad readback.

Behaviour:
- Reset values: busy_o=0, done_o=0, nack_o=0, scl_o=1, sda_oe_o=0, state IDLE, divider=0.
  - Reset mid-frame releases both lines on the next edge with no STOP. This is acceptable.
- Accept: in IDLE with en_i=1 and start_i=1.
  - On that edge: latch {DEV_ADDR,1'b0,data_i} into a 24-bit shift register, set busy_o=1, clear the divider.
  - busy_o is therefore high in the very next cycle. The sequencer treats busy low there as NACK.
- start_i while busy_o=1 is ignored; the latched data does not change.
- Divider: counts 0..CLK_DIV-1 on en_i cycles. A tick at CLK_DIV-1 advances one quarter-phase.
- States: IDLE -> START -> BIT -> ACK -> (BIT | STOP) -> FIN -> IDLE.
- START, 2 quarters:
  - q0: SCL=1, SDA released.
  - q1: SCL=1, SDA low.
- BIT, 8 per byte, 4 quarters each; MSB first from the shift register:
  - q0: SCL=0, drive bit.
  - q1 and q2: SCL=1.
  - q3: SCL=0.
- ACK, 4 quarters, SDA released:
  - Sample sda_i at the end of q2.
  - 0 means ACK. Go to the next byte, or to STOP after byte 3.
  - 1 means NACK. Set an internal nack flag and go directly to STOP.
- STOP, 3 quarters:
  - q0: SCL=0, SDA low.
  - q1: SCL=1, SDA low.
  - q2: SCL=1, SDA released.
- FIN, 1 cycle:
  - Success: done_o=1 with busy_o still 1. busy_o=0 on the next cycle.
  - NACK: busy_o=0 and nack_o=1 on the same edge; done_o stays 0.
- Success latency: done_o rises exactly 113*CLK_DIV cycles after the accept edge (2+108+3 quarters), with en_i held high.
- NACK on the address byte: busy_o falls 41*CLK_DIV cycles after accept (2+36+3 quarters).
- Outputs are registered; no combinational path from inputs to outputs.
- en_i low mid-frame holds SCL/SDA at their current levels; the frame resumes without glitch.

Decomposition:
- Package i2c_pkg:
  - state enum (IDLE, START, BIT, ACK, STOP, FIN);
  - quarter-phase constants;
  - BYTES_PER_FRAME=3, BITS_PER_BYTE=8;
  - START_Q=2, STOP_Q=3.
- Sub-module i2c_quarter_tick: parameterised divider with clear, enable, and a tick output.

Test Plan:
- CLK_DIV=4, data 16'h0C10, slave ACKs all bytes -> SDA samples at SCL high read 0x34, ACK, 0x0C, ACK, 0x10, ACK. done_o pulses at cycle 452 after accept. busy_o falls at 453. nack_o never asserts.
- Slave NACKs the address -> STOP follows the 9th bit. busy_o falls at cycle 164 with a nack_o pulse. done_o stays 0. Only 9 SCL high pulses.
- NACK on byte 2 -> 18 SCL pulses, then STOP. nack_o pulse, no done_o.
- start_i re-pulsed with 16'hFFFF mid-frame -> ignored; the frame still carries the original data.
- en_i low for 50 cycles inside a BIT phase -> SCL/SDA frozen. done_o delayed by exactly 50 cycles.
- rst_i at cycle 200 -> next edge: scl_o=1, sda_oe_o=0, busy_o=0. A subsequent start runs a full, correct frame.
- Sequencer-style driver with ten words 1E00..0C00 back to back -> ten frames with matching payloads and ten done_o pulses.
